// File: rtl/block_matmul_scheduler_if.sv
// rtl/block_matmul_scheduler_if.sv - handshake bundle between the matmul scheduler and the MAC tile engine / accumulator
//
// Purpose: groups the tile-engine and accumulator handshake plus the A/B/C tile select indices.
// Signals:
//   clear_acc          scheduler -> accumulator   1-cycle pulse, start_new_computation
//   tile_start         scheduler -> MAC engine    1-cycle pulse, load A/B tiles and compute
//   tile_done          MAC engine -> scheduler    1-cycle pulse, partial result valid
//   accumulate_result  scheduler -> accumulator   level request, held until accumulation_done
//   accumulation_done  accumulator -> scheduler   ack for accumulate_result
//   a_row_idx/a_col_idx, b_row_idx/b_col_idx, c_row_idx/c_col_idx  tile selects
// Modports: master = scheduler side, slave = engine/accumulator side.
interface block_matmul_scheduler_if #(
  parameter int IDX_WIDTH = 2
);
  logic                 clear_acc;
  logic                 tile_start;
  logic                 tile_done;
  logic                 accumulate_result;
  logic                 accumulation_done;
  logic [IDX_WIDTH-1:0] a_row_idx;
  logic [IDX_WIDTH-1:0] a_col_idx;
  logic [IDX_WIDTH-1:0] b_row_idx;
  logic [IDX_WIDTH-1:0] b_col_idx;
  logic [IDX_WIDTH-1:0] c_row_idx;
  logic [IDX_WIDTH-1:0] c_col_idx;

  modport master (
    output clear_acc, tile_start, accumulate_result,
    output a_row_idx, a_col_idx, b_row_idx, b_col_idx, c_row_idx, c_col_idx,
    input  tile_done, accumulation_done
  );

  modport slave (
    input  clear_acc, tile_start, accumulate_result,
    input  a_row_idx, a_col_idx, b_row_idx, b_col_idx, c_row_idx, c_col_idx,
    output tile_done, accumulation_done
  );
endinterface

// File: rtl/block_matmul_scheduler.sv
// rtl/block_matmul_scheduler.sv - sequences a tiled matrix multiply over a block MAC engine and result accumulator
//
// Purpose: clears the accumulator once, then for every output block (ci,cj) walks k over all
//   blocks, issuing one tile compute A(ci,k) x B(k,cj) followed by one accumulate into C(ci,cj).
//   A watchdog aborts the run with a sticky error if the engine or accumulator stops answering.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        1-cycle request, honoured only when idle
//   busy         high from the cycle after an accepted start until the run ends
//   done         1-cycle pulse after all NB^3 steps are accumulated
//   error        sticky watchdog timeout, cleared by the next accepted start
//   tiles_done   completed accumulate steps in the current run
//   eng          master side of the engine/accumulator handshake and tile selects
module block_matmul_scheduler #(
  parameter int MATRIX_SIZE    = 128,
  parameter int BLOCK_SIZE     = 64,
  parameter int IDX_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [CNT_WIDTH-1:0]     tiles_done,
  block_matmul_scheduler_if.master eng
);

  localparam int                   NB       = MATRIX_SIZE / BLOCK_SIZE;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NB - 1);
  localparam logic [CNT_WIDTH-1:0] WD_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_COMPUTE,
    S_ACCUM,
    S_GAP,
    S_FINISH
  } state_t;

  state_t               state;
  logic [IDX_WIDTH-1:0] ci;
  logic [IDX_WIDTH-1:0] cj;
  logic [IDX_WIDTH-1:0] k;
  logic [CNT_WIDTH-1:0] wd_cnt;
  logic                 clear_acc_r;
  logic                 tile_start_r;
  logic                 acc_req_r;
  logic                 last_step;

  assign last_step = (ci == LAST_IDX) && (cj == LAST_IDX) && (k == LAST_IDX);

  assign eng.clear_acc         = clear_acc_r;
  assign eng.tile_start        = tile_start_r;
  assign eng.accumulate_result = acc_req_r;
  assign eng.a_row_idx         = ci;
  assign eng.a_col_idx         = k;
  assign eng.b_row_idx         = k;
  assign eng.b_col_idx         = cj;
  assign eng.c_row_idx         = ci;
  assign eng.c_col_idx         = cj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      tiles_done   <= '0;
      ci           <= '0;
      cj           <= '0;
      k            <= '0;
      wd_cnt       <= '0;
      clear_acc_r  <= 1'b0;
      tile_start_r <= 1'b0;
      acc_req_r    <= 1'b0;
    end else begin
      // Single-cycle strobes drop unless a state re-asserts them below.
      clear_acc_r  <= 1'b0;
      tile_start_r <= 1'b0;
      done         <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_CLEAR;
            busy        <= 1'b1;
            error       <= 1'b0;
            tiles_done  <= '0;
            ci          <= '0;
            cj          <= '0;
            k           <= '0;
            clear_acc_r <= 1'b1;
          end
        end

        S_CLEAR: begin
          state        <= S_ISSUE;
          tile_start_r <= 1'b1;
        end

        S_ISSUE: begin
          state  <= S_COMPUTE;
          wd_cnt <= '0;
        end

        S_COMPUTE: begin
          // The awaited input is checked first so it wins over a same-cycle timeout.
          if (eng.tile_done) begin
            state     <= S_ACCUM;
            acc_req_r <= 1'b1;
            wd_cnt    <= '0;
          end else if (wd_cnt == WD_LIMIT) begin
            state     <= S_IDLE;
            error     <= 1'b1;
            busy      <= 1'b0;
            acc_req_r <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        S_ACCUM: begin
          if (eng.accumulation_done) begin
            state     <= S_GAP;
            acc_req_r <= 1'b0;
          end else if (wd_cnt == WD_LIMIT) begin
            state     <= S_IDLE;
            error     <= 1'b1;
            busy      <= 1'b0;
            acc_req_r <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        S_GAP: begin
          // The accumulator reacts to a rising edge on accumulate_result, so this
          // state guarantees at least one low cycle before the next request.
          tiles_done <= tiles_done + 1'b1;
          if (last_step) begin
            // Indices are left on the final block so they hold in IDLE.
            state <= S_FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state        <= S_ISSUE;
            tile_start_r <= 1'b1;
            if (k != LAST_IDX) begin
              k <= k + 1'b1;
            end else begin
              k <= '0;
              if (cj != LAST_IDX) begin
                cj <= cj + 1'b1;
              end else begin
                cj <= '0;
                ci <= ci + 1'b1;
              end
            end
          end
        end

        S_FINISH: begin
          state <= S_IDLE;
        end

        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          acc_req_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_matmul_scheduler.sv
// tb/tb_block_matmul_scheduler.sv - directed self-checking bench for block_matmul_scheduler
module tb_block_matmul_scheduler;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] tiles_done;

  block_matmul_scheduler_if #(.IDX_WIDTH(2)) eng_if ();

  block_matmul_scheduler #(
    .MATRIX_SIZE   (128),
    .BLOCK_SIZE    (64),
    .IDX_WIDTH     (2),
    .TIMEOUT_CYCLES(16),
    .CNT_WIDTH     (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .tiles_done(tiles_done),
    .eng       (eng_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycle counter advanced on the active edge; everything else samples on the falling edge.
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Responder / monitor state
  bit tile_en  = 1'b1;
  bit acc_hold = 1'b0;
  int tdly     = 0;

  int clr_cnt, clr_cyc, ts_cnt, ts_cyc, done_cnt, done_cyc, busy_cnt;
  int acc_rises, stab_err, idx_err, cur_code;
  bit prev_acc, busy_at_done;
  int seq [16];

  function automatic int cur_idx_code();
    return int'(eng_if.a_row_idx) * 4 + int'(eng_if.b_col_idx) * 2 + int'(eng_if.a_col_idx);
  endfunction

  task automatic clear_mon();
    clr_cnt = 0; clr_cyc = -1; ts_cnt = 0; ts_cyc = -1; done_cnt = 0; done_cyc = -1;
    busy_cnt = 0; acc_rises = 0; stab_err = 0; idx_err = 0; cur_code = -1;
    prev_acc = 1'b0; busy_at_done = 1'b1;
    for (int i = 0; i < 16; i++) seq[i] = -1;
  endtask

  initial begin
    eng_if.tile_done = 1'b0;
    eng_if.accumulation_done = 1'b0;
    forever begin
      @(negedge clk);
      // MAC engine: tile_done 3 cycles after tile_start
      eng_if.tile_done = 1'b0;
      if (tdly > 0) begin
        tdly--;
        if (tdly == 0) eng_if.tile_done = 1'b1;
      end
      if (eng_if.tile_start) begin
        if (ts_cnt == 0) ts_cyc = cyc;
        if (ts_cnt < 16) seq[ts_cnt] = cur_idx_code();
        ts_cnt++;
        cur_code = cur_idx_code();
        if (eng_if.b_row_idx != eng_if.a_col_idx || eng_if.c_row_idx != eng_if.a_row_idx ||
            eng_if.c_col_idx != eng_if.b_col_idx)
          idx_err++;
        tdly = tile_en ? 3 : 0;
      end
      // Accumulator: ack as soon as the request is seen, or stuck high
      eng_if.accumulation_done = acc_hold ? 1'b1 : eng_if.accumulate_result;
      if (eng_if.clear_acc) begin
        clr_cnt++;
        if (clr_cnt == 1) clr_cyc = cyc;
      end
      if (eng_if.accumulate_result && cur_idx_code() != cur_code) stab_err++;
      if (eng_if.accumulate_result && !prev_acc) acc_rises++;
      prev_acc = eng_if.accumulate_result;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
    end
  end

  task automatic start_run(output int sc, output logic err_at_accept);
    @(posedge clk);
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    sc = cyc;
    @(negedge clk);
    start = 1'b0;
    err_at_accept = error;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0 && !error; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_run(input string t, input int sc);
    check({t, "_clr_cnt"}, clr_cnt, 1);
    check({t, "_clr_lat"}, clr_cyc - sc, 1);
    check({t, "_ts_lat"}, ts_cyc - sc, 2);
    check({t, "_done_cnt"}, done_cnt, 1);
    check({t, "_ts_cnt"}, ts_cnt, 8);
    check({t, "_tiles_done"}, tiles_done, 8);
    check({t, "_busy_cycles"}, busy_cnt, done_cyc - sc - 1);
    check({t, "_busy_at_done"}, busy_at_done, 0);
    check({t, "_acc_rises"}, acc_rises, 8);
    check({t, "_idx_stable"}, stab_err, 0);
    check({t, "_idx_map"}, idx_err, 0);
    check({t, "_error"}, error, 0);
    for (int i = 0; i < 8; i++) check($sformatf("%s_seq%0d", t, i), seq[i], i);
  endtask

  function automatic logic [63:0] all_outs();
    return {30'd0, busy, done, error, eng_if.clear_acc, eng_if.tile_start, eng_if.accumulate_result,
            eng_if.a_row_idx, eng_if.a_col_idx, eng_if.b_row_idx, eng_if.b_col_idx,
            eng_if.c_row_idx, eng_if.c_col_idx, tiles_done};
  endfunction

  initial begin
    int   sc;
    logic ea;
    rst_n = 1'b0;
    start = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain full run
    start_run(sc, ea);
    wait_done(300);
    check_run("full", sc);

    // start pulses during COMPUTE and ACCUM are ignored
    start_run(sc, ea);
    for (int i = 0; i < 100 && ts_cnt < 3; i++) @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && eng_if.accumulate_result !== 1'b1; i++) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(300);
    check_run("midstart", sc);

    // Watchdog: engine never answers
    tile_en = 1'b0;
    start_run(sc, ea);
    for (int i = 0; i < 50 && cyc != sc + 18; i++) @(negedge clk);
    check("to_err_before_limit", error, 0);
    check("to_busy_before_limit", busy, 1);
    @(negedge clk);
    check("to_err", error, 1);
    check("to_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("to_no_done", done_cnt, 0);
    check("to_err_sticky", error, 1);
    check("to_acc_req", eng_if.accumulate_result, 0);
    tile_en = 1'b1;
    start_run(sc, ea);
    check("to_err_cleared", ea, 0);
    wait_done(300);
    check_run("after_to", sc);

    // Accumulator ack stuck high
    acc_hold = 1'b1;
    start_run(sc, ea);
    wait_done(300);
    check_run("hold", sc);
    acc_hold = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset during step 5 ACCUM
    start_run(sc, ea);
    for (int i = 0; i < 300 && !(tiles_done == 16'd4 && eng_if.accumulate_result === 1'b1); i++)
      @(negedge clk);
    check("rst5_in_accum", {eng_if.accumulate_result, tiles_done}, {1'b1, 16'd4});
    #2 rst_n = 1'b0;
    #1 check("rst5_outs", all_outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst5_no_done", done_cnt, 0);
    start_run(sc, ea);
    wait_done(300);
    check_run("after_rst", sc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
